// File: rtl/enc_gen_pkg.sv
// Shared types and default widths for the quadrature-encoder pulse generator.
package enc_gen_pkg;

  localparam int unsigned DEF_HALF_W  = 32;
  localparam int unsigned DEF_PPR_W   = 16;
  localparam int unsigned DEF_REV_W   = 32;
  localparam int unsigned PULSE_CNT_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/enc_tick_div.sv
// Loadable down-counter: 1-cycle tick while at terminal count, then auto-reload.
// The first interval uses load_val, every later one reload_val.
module enc_tick_div #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] reload_val,
  output logic         tick
);

  logic [W-1:0] cnt_q;

  assign tick = en && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en) begin
      if (cnt_q == '0) cnt_q <= reload_val;
      else             cnt_q <= cnt_q - W'(1);
    end
  end

endmodule

// File: rtl/enc_pulse_gen.sv
// Quadrature-encoder emulator: A pulse train, Z index, optional B channel.
// Optional feature: define ENC_GEN_QUAD_B_EN for the 90-degree lagging B output.
module enc_pulse_gen
  import enc_gen_pkg::*;
#(
  parameter int unsigned HALF_W = DEF_HALF_W,
  parameter int unsigned PPR_W  = DEF_PPR_W,
  parameter int unsigned REV_W  = DEF_REV_W
) (
  input  logic                   CLK,
  input  logic                   I_RST_N,
  input  logic                   I_START,
  input  logic                   I_STOP,
  input  logic [HALF_W-1:0]      I_HALF_PERIOD,
  input  logic [PPR_W-1:0]       I_PPR,
  input  logic [REV_W-1:0]       I_NUM_REV,
  output logic                   O_A,
  output logic                   O_B,
  output logic                   O_Z,
  output logic                   O_BUSY,
  output logic                   O_DONE,
  output logic                   O_ERR,
  output logic [PULSE_CNT_W-1:0] O_PULSE_CNT
);

  state_t                 state;
  logic [PPR_W-1:0]       ppr_q;
  logic [PPR_W-1:0]       idx_q;
  logic [REV_W-1:0]       nrev_q;
  logic [REV_W-1:0]       rev_q;
  logic [HALF_W-1:0]      reload_q;
  logic [PULSE_CNT_W-1:0] cnt_q;
  logic                   a_q;
  logic                   z_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   err_q;
  logic                   stop_pend_q;

  logic                   cfg_ok;
  logic                   start_ok;
  logic [HALF_W-1:0]      reload_nxt;
  logic                   tick;
  logic                   a_rise;
  logic                   a_fall;
  logic                   last_pulse;
  logic                   idx_wrap;
  logic                   finish;

`ifdef ENC_GEN_QUAD_B_EN
  logic b_q;
  logic b_rise;
  logic b_fall;
`endif

  always_comb begin
    cfg_ok     = 1'b0;
    reload_nxt = '0;
`ifdef ENC_GEN_QUAD_B_EN
    cfg_ok     = (I_PPR != '0) && (I_HALF_PERIOD >= HALF_W'(2)) && !I_HALF_PERIOD[0];
    reload_nxt = (I_HALF_PERIOD >> 1) - HALF_W'(1);
`else
    cfg_ok     = (I_PPR != '0) && (I_HALF_PERIOD != '0);
    reload_nxt = I_HALF_PERIOD - HALF_W'(1);
`endif
    start_ok   = (state == ST_IDLE) && I_START && cfg_ok;
  end

  // The first interval is always a full half-period so A edge timing is the same
  // with or without B; afterwards the divider ticks at quarter rate in quad mode.
  enc_tick_div #(
    .W (HALF_W)
  ) u_div (
    .clk        (CLK),
    .rst_n      (I_RST_N),
    .load       (start_ok),
    .en         (state == ST_RUN),
    .load_val   (I_HALF_PERIOD - HALF_W'(1)),
    .reload_val (reload_q),
    .tick       (tick)
  );

  always_comb begin
    a_rise = 1'b0;
    a_fall = 1'b0;
`ifdef ENC_GEN_QUAD_B_EN
    // Gray phase is carried by {A,B}: 00 -> 10 -> 11 -> 01 -> 00.
    a_rise = tick && !a_q && !b_q;
    b_rise = tick &&  a_q && !b_q;
    a_fall = tick &&  a_q &&  b_q;
    b_fall = tick && !a_q &&  b_q;
`else
    a_rise = tick && !a_q;
    a_fall = tick &&  a_q;
`endif
    idx_wrap   = (idx_q == ppr_q - PPR_W'(1));
    last_pulse = (nrev_q != '0) && (rev_q == nrev_q) && (idx_q == '0);
    // A stop while A is high waits for the fall so the last pulse is never cut.
    finish     = a_q ? (a_fall && (stop_pend_q || I_STOP || last_pulse)) : I_STOP;
  end

  always_ff @(posedge CLK) begin
    if (!I_RST_N) begin
      state       <= ST_IDLE;
      ppr_q       <= '0;
      idx_q       <= '0;
      nrev_q      <= '0;
      rev_q       <= '0;
      reload_q    <= '0;
      cnt_q       <= '0;
      a_q         <= 1'b0;
      z_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      stop_pend_q <= 1'b0;
`ifdef ENC_GEN_QUAD_B_EN
      b_q         <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (I_START) begin
            if (cfg_ok) begin
              ppr_q       <= I_PPR;
              nrev_q      <= I_NUM_REV;
              reload_q    <= reload_nxt;
              cnt_q       <= '0;
              idx_q       <= '0;
              rev_q       <= '0;
              a_q         <= 1'b0;
              z_q         <= 1'b0;
              stop_pend_q <= 1'b0;
              busy_q      <= 1'b1;
              state       <= ST_RUN;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (finish) begin
            a_q    <= 1'b0;
            z_q    <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= ST_DONE;
`ifdef ENC_GEN_QUAD_B_EN
            b_q    <= 1'b0;
`endif
          end else begin
            if (I_STOP) stop_pend_q <= 1'b1;
            if (a_rise) begin
              a_q   <= 1'b1;
              z_q   <= (idx_q == '0);
              cnt_q <= cnt_q + PULSE_CNT_W'(1);
              if (idx_wrap) begin
                idx_q <= '0;
                rev_q <= rev_q + REV_W'(1);
              end else begin
                idx_q <= idx_q + PPR_W'(1);
              end
            end
            if (a_fall) begin
              a_q <= 1'b0;
              z_q <= 1'b0;
            end
`ifdef ENC_GEN_QUAD_B_EN
            if (b_rise) b_q <= 1'b1;
            if (b_fall) b_q <= 1'b0;
`endif
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign O_A         = a_q;
  assign O_Z         = z_q;
  assign O_BUSY      = busy_q;
  assign O_DONE      = done_q;
  assign O_ERR       = err_q;
  assign O_PULSE_CNT = cnt_q;
`ifdef ENC_GEN_QUAD_B_EN
  assign O_B = b_q;
`else
  assign O_B = 1'b0;
`endif

endmodule
